// File: rtl/sel_seq_moore_pkg.sv
// Shared definitions for the sel_seq_moore select-line generator.
// Holds the FSM state width and the legal state encodings; codes 2 and 3
// are unused and recover to S_SEARCH in the top module.
package sel_seq_moore_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] S_SEARCH = 2'd0;
  localparam logic [STATE_W-1:0] S_HOLD   = 2'd1;

  // The hold counter is sized for the largest legal HOLD value (255).
  localparam int HOLD_CNT_W = 8;

endpackage

// File: rtl/sel_seq_moore_bit_history.sv
// Serial history shift register, saturating fill counter and pattern comparator.
// Ports: clk, reset (sync, active-high), din/din_valid (qualified serial bit),
//        match (combinational: the accepted bit completes PATTERN this cycle).
module sel_seq_moore_bit_history #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  input  logic din_valid,
  output logic match
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  hist;
  logic [FILL_W-1:0] fill;
  logic [PAT_W-1:0]  cand;
  logic              unused_oldest;

  // The oldest bit only matters for debug visibility: the comparison window
  // is the newest PAT_W-1 stored bits plus the incoming bit.
  assign unused_oldest = hist[PAT_W-1];
  assign cand          = {hist[PAT_W-2:0], din};

  // fill counts bits accepted since the last match, so a match can only use
  // bits that were not part of a previous match (non-overlapping detection).
  assign match = din_valid && (int'(fill) >= PAT_W - 1) && (cand == PATTERN);

  always_ff @(posedge clk) begin
    if (reset) begin
      hist <= '0;
      fill <= '0;
    end else if (din_valid) begin
      hist <= cand;
      if (match) begin
        fill <= '0;
      end else if (int'(fill) < PAT_W) begin
        fill <= fill + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sel_seq_moore.sv
// Moore pattern detector driving the select line of a downstream 2:1 mux.
// Ports: clk, reset (sync, active-high), din/din_valid (serial input),
//        sel, match_pulse, match_count (saturating), state_o (debug).
module sel_seq_moore
  import sel_seq_moore_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int               HOLD    = 3,
  parameter int               CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               din,
  input  logic               din_valid,
  output logic               sel,
  output logic               match_pulse,
  output logic [CNT_W-1:0]   match_count,
  output logic [STATE_W-1:0] state_o
);

  localparam logic [HOLD_CNT_W-1:0] HOLD_LD = HOLD_CNT_W'(HOLD - 1);

  logic                  match;
  logic [STATE_W-1:0]    state;
  logic [STATE_W-1:0]    state_nxt;
  logic [HOLD_CNT_W-1:0] hold_cnt;
  logic [HOLD_CNT_W-1:0] hold_nxt;

  sel_seq_moore_bit_history #(
    .PAT_W  (PAT_W),
    .PATTERN(PATTERN)
  ) u_hist (
    .clk      (clk),
    .reset    (reset),
    .din      (din),
    .din_valid(din_valid),
    .match    (match)
  );

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    case (state)
      S_SEARCH: begin
        if (match) begin
          state_nxt = S_HOLD;
          hold_nxt  = HOLD_LD;
        end
      end
      S_HOLD: begin
        // A match retriggers the hold window, even on its final cycle.
        if (match) begin
          hold_nxt = HOLD_LD;
        end else if (hold_cnt == '0) begin
          state_nxt = S_SEARCH;
        end else begin
          hold_nxt = hold_cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = S_SEARCH;
        hold_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_SEARCH;
      hold_cnt    <= '0;
      sel         <= 1'b0;
      match_pulse <= 1'b0;
      match_count <= '0;
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_nxt;
      // sel is registered from the next-state decode so it is a clean flop
      // output that always agrees with state.
      sel         <= (state_nxt == S_HOLD);
      match_pulse <= match;
      if (match && (match_count != '1)) begin
        match_count <= match_count + 1'b1;
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_sel_seq_moore.sv
// Self-checking bench: three DUT variants (default, HOLD=8, CNT_W=2) share one
// stimulus stream and are compared each cycle against a queue-based model.
module tb_sel_seq_moore;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic din = 1'b0;
  logic din_valid = 1'b0;

  logic       sel_a   [3];
  logic       pulse_a [3];
  logic [1:0] state_a [3];
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sel_seq_moore u0 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .sel(sel_a[0]), .match_pulse(pulse_a[0]), .match_count(cnt0), .state_o(state_a[0])
  );

  sel_seq_moore #(.HOLD(8)) u1 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .sel(sel_a[1]), .match_pulse(pulse_a[1]), .match_count(cnt1), .state_o(state_a[1])
  );

  sel_seq_moore #(.CNT_W(2)) u2 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .sel(sel_a[2]), .match_pulse(pulse_a[2]), .match_count(cnt2), .state_o(state_a[2])
  );

  function automatic int dut_cnt(int i);
    if (i == 0) return int'(cnt0);
    if (i == 1) return int'(cnt1);
    return int'(cnt2);
  endfunction

  task automatic chk(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // q holds accepted bits not yet consumed by a match; rem is the number of
  // cycles sel must still be high.
  bit q[$];
  int rem   [3] = '{0, 0, 0};
  int cnt   [3] = '{0, 0, 0};
  int pulse [3] = '{0, 0, 0};
  int hold_v[3] = '{3, 8, 3};
  int cmax  [3] = '{255, 255, 3};
  bit m;
  bit model_ready = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      for (int i = 0; i < 3; i++) begin
        rem[i] = 0; cnt[i] = 0; pulse[i] = 0;
      end
    end else begin
      m = 1'b0;
      if (din_valid) begin
        q.push_back(din);
        if (q.size() >= 4 &&
            {q[q.size()-4], q[q.size()-3], q[q.size()-2], q[q.size()-1]} == 4'b1011) begin
          m = 1'b1;
          q.delete();
        end else if (q.size() > 4) begin
          void'(q.pop_front());
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (m) begin
          rem[i] = hold_v[i];
          pulse[i] = 1;
          if (cnt[i] < cmax[i]) cnt[i]++;
        end else begin
          pulse[i] = 0;
          if (rem[i] > 0) rem[i]--;
        end
      end
    end
    model_ready = 1'b1;
  end

  always @(negedge clk) begin
    if (model_ready) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("sel[%0d]", i),   int'(sel_a[i]),   int'(rem[i] > 0));
        chk($sformatf("pulse[%0d]", i), int'(pulse_a[i]), pulse[i]);
        chk($sformatf("count[%0d]", i), dut_cnt(i),       cnt[i]);
        chk($sformatf("state[%0d]", i), int'(state_a[i]), (rem[i] > 0) ? 1 : 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic r, input logic v, input logic d);
    reset = r; din_valid = v; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic send4(input logic [3:0] p);
    for (int i = 3; i >= 0; i--) step(1'b0, 1'b1, p[i]);
  endtask

  initial begin
    int sat_exp[5];
    sat_exp = '{1, 2, 3, 3, 3};

    // Reset then stream 1,0,1,1
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("rst_sel", int'(sel_a[0]), 0);
    chk("rst_cnt", int'(cnt0), 0);
    send4(4'b1011);
    chk("t1_sel_k1", int'(sel_a[0]), 1);
    chk("t1_pulse_k1", int'(pulse_a[0]), 1);
    chk("t1_model_cnt", cnt[0], 1);
    idle(1);
    chk("t1_sel_k2", int'(sel_a[0]), 1);
    chk("t1_pulse_k2", int'(pulse_a[0]), 0);
    idle(1);
    chk("t1_sel_k3", int'(sel_a[0]), 1);
    idle(1);
    chk("t1_sel_k4", int'(sel_a[0]), 0);
    chk("t1_cnt", int'(cnt0), 1);
    idle(8);

    // Gapped bits
    begin
      logic [3:0] p;
      p = 4'b1011;
      for (int i = 3; i >= 0; i--) begin
        step(1'b0, 1'b1, p[i]);
        if (i != 0) idle(2);
      end
    end
    chk("gap_pulse", int'(pulse_a[0]), 1);
    chk("gap_cnt", int'(cnt0), 2);
    idle(10);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1);
    chk("novalid_sel", int'(sel_a[0]), 0);
    chk("novalid_cnt", int'(cnt0), 2);

    // Non-overlap: 1,0,1,1,0,1,1 -> one match
    send4(4'b1011);
    chk("novl_first", int'(cnt0), 3);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    chk("novl_no_pulse", int'(pulse_a[0]), 0);
    chk("novl_cnt", int'(cnt0), 3);
    send4(4'b1011);
    chk("novl_second_pulse", int'(pulse_a[0]), 1);
    chk("novl_second_cnt", int'(cnt0), 4);
    idle(10);

    // Retrigger on the HOLD=8 variant
    step(1'b1, 1'b0, 1'b0);
    send4(4'b1011);
    for (int i = 3; i >= 0; i--) begin
      step(1'b0, 1'b1, (i == 2) ? 1'b0 : 1'b1);
      chk("rtg_sel_cont", int'(sel_a[1]), 1);
    end
    chk("rtg_pulse2", int'(pulse_a[1]), 1);
    idle(7);
    chk("rtg_sel_last", int'(sel_a[1]), 1);
    idle(1);
    chk("rtg_sel_off", int'(sel_a[1]), 0);
    chk("rtg_cnt", int'(cnt1), 2);
    idle(3);

    // Reset mid-HOLD, and a pattern completing on a reset cycle
    send4(4'b1011);
    idle(1);
    step(1'b1, 1'b1, 1'b1);
    chk("mid_sel", int'(sel_a[0]), 0);
    chk("mid_pulse", int'(pulse_a[0]), 0);
    chk("mid_cnt", int'(cnt0), 0);
    chk("mid_sel_h8", int'(sel_a[1]), 0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    chk("rstpat_pulse", int'(pulse_a[0]), 0);
    chk("rstpat_cnt", int'(cnt0), 0);
    step(1'b0, 1'b1, 1'b1);
    chk("rstpat_hist_clr", int'(pulse_a[0]), 0);
    idle(3);

    // Saturation on the CNT_W=2 variant
    step(1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 5; n++) begin
      send4(4'b1011);
      chk($sformatf("sat_pulse%0d", n), int'(pulse_a[2]), 1);
      chk($sformatf("sat_cnt%0d", n), int'(cnt2), sat_exp[n]);
      idle(4);
    end
    chk("sat_model", cnt[2], 3);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 99) == 0),
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)));
    end
    idle(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
